// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-side types and configuration codes
// Contents: receive controller state enum, character-width and baud-select codes,
// and the codes the configuration registers take at reset.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_RECV  = 2'd2,
        ST_FULL  = 2'd3
    } rx_state_t;

    // Character width codes (o_rx_bits)
    localparam logic [1:0] BITS_5 = 2'b00;
    localparam logic [1:0] BITS_6 = 2'b01;
    localparam logic [1:0] BITS_7 = 2'b10;
    localparam logic [1:0] BITS_8 = 2'b11;

    // Baud select codes (o_rx_baud)
    localparam logic [1:0] BAUD_9600   = 2'b00;
    localparam logic [1:0] BAUD_19200  = 2'b01;
    localparam logic [1:0] BAUD_57600  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    localparam logic [1:0] BITS_RESET = BITS_8;
    localparam logic [1:0] BAUD_RESET = BAUD_9600;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - single-clock receive FIFO, first-word-fall-through
// Ports: clk, rst_n (async active-low); push/push_data write side;
// ready pops the head when valid; data/valid present the head;
// count is the occupancy; drop pulses combinationally when a push is refused.
module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    ready,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  accept;

    assign valid  = (count != '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign pop    = valid && ready;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO
    // still accepts the push.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: FSM, config shadow, idle timeout, RX FIFO
// Ports: clk, rst_n (async active-low); i_enable, i_clr (overflow clear);
// i_cfg_* configuration write; o_rx_* receiver control, i_rx_* receiver status/data;
// o_data/o_valid/i_ready output stream; o_count, o_overflow, o_timeout status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic                    i_clr,
    input  logic                    i_cfg_wr,
    input  logic                    i_cfg_parity,
    input  logic [1:0]              i_cfg_bits,
    input  logic [1:0]              i_cfg_baud,
    input  logic [15:0]             i_cfg_timeout,
    output logic                    o_rx_en,
    output logic                    o_rx_parity,
    output logic [1:0]              o_rx_bits,
    output logic [1:0]              o_rx_baud,
    input  logic [DATA_WIDTH-1:0]   i_rx_data,
    input  logic                    i_rx_busy,
    input  logic                    i_rx_done,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    output logic                    o_timeout
);
    localparam int CW = $clog2(DEPTH) + 1;

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic        fifo_full;
    logic        fifo_drop;

    logic        pend_valid;
    logic        pend_parity;
    logic [1:0]  pend_bits;
    logic [1:0]  pend_baud;

    logic [15:0] idle_cnt;
    logic [15:0] idle_nxt;
    logic        timeout_fired;
    logic        timeout_hit;

    uart_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (i_rx_done),
        .push_data (i_rx_data),
        .ready     (i_ready),
        .data      (o_data),
        .valid     (o_valid),
        .count     (o_count),
        .drop      (fifo_drop)
    );

    assign fifo_full = (o_count == CW'(DEPTH));

    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:   state_nxt = ST_ARMED;
                ST_ARMED: if (fifo_full) state_nxt = ST_FULL;
                          else if (i_rx_busy) state_nxt = ST_RECV;
                ST_RECV:  if (fifo_full) state_nxt = ST_FULL;
                          else if (i_rx_done) state_nxt = ST_ARMED;
                ST_FULL:  if (!fifo_full) state_nxt = ST_ARMED;
                default:  state_nxt = ST_OFF;
            endcase
        end
    end

    // o_rx_en is registered from the next state so it always matches state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            o_rx_en <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_rx_en <= (state_nxt == ST_ARMED) || (state_nxt == ST_RECV);
        end
    end

    // Config writes never change the receiver setup mid-frame: a write seen
    // while busy is parked (latest wins) and applied once the line goes idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rx_parity <= 1'b0;
            o_rx_bits   <= BITS_RESET;
            o_rx_baud   <= BAUD_RESET;
            pend_valid  <= 1'b0;
            pend_parity <= 1'b0;
            pend_bits   <= BITS_RESET;
            pend_baud   <= BAUD_RESET;
        end else if (i_cfg_wr && !i_rx_busy) begin
            o_rx_parity <= i_cfg_parity;
            o_rx_bits   <= i_cfg_bits;
            o_rx_baud   <= i_cfg_baud;
            pend_valid  <= 1'b0;
        end else if (i_cfg_wr) begin
            pend_valid  <= 1'b1;
            pend_parity <= i_cfg_parity;
            pend_bits   <= i_cfg_bits;
            pend_baud   <= i_cfg_baud;
        end else if (pend_valid && !i_rx_busy) begin
            o_rx_parity <= pend_parity;
            o_rx_bits   <= pend_bits;
            o_rx_baud   <= pend_baud;
            pend_valid  <= 1'b0;
        end
    end

    // The timeout is judged on the value the counter is about to take, so the
    // pulse appears on the same edge at which the counter reaches the limit.
    assign idle_nxt    = (i_rx_done || i_rx_busy) ? 16'd0 :
                         (idle_cnt == 16'hFFFF)   ? idle_cnt : idle_cnt + 16'd1;
    assign timeout_hit = (idle_nxt == i_cfg_timeout) && (i_cfg_timeout != 16'd0) &&
                         (o_count != '0) && !timeout_fired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt      <= 16'd0;
            timeout_fired <= 1'b0;
            o_timeout     <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            idle_cnt  <= idle_nxt;
            o_timeout <= timeout_hit;
            if (i_rx_done) begin
                timeout_fired <= 1'b0;
            end else if (timeout_hit) begin
                timeout_fired <= 1'b1;
            end
            // A fresh drop wins over a clear in the same cycle.
            if (fifo_drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule
